// File: rtl/timer_bank.sv
// timer_bank: a bank of independent centisecond timers sharing one prescaler.
// Each channel runs either as a countdown alarm or as an up-counting stopwatch.
// Optional lap FIFO for SPLIT captures is enabled by defining TIMER_LAP_FIFO_EN.
// Without that macro, SPLIT and CLR_OVF do nothing and the lap port is tied to 0.

package timer_bank_pkg;
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_STSP    = 3'd2;
    localparam logic [2:0] OP_SPLIT   = 3'd3;
    localparam logic [2:0] OP_CLEAR   = 3'd4;
    localparam logic [2:0] OP_ACK     = 3'd5;
    localparam logic [2:0] OP_MODE    = 3'd6;
    localparam logic [2:0] OP_CLR_OVF = 3'd7;
endpackage

// Per-channel timer. The hit input means "a command targets this channel
// this cycle". A hit always wins over the tick, so the tick is lost.
module timer_chan
    import timer_bank_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clockSignal,
    input  logic               resetN,
    input  logic               tick,
    input  logic               hit,
    input  logic [2:0]         op,
    input  logic [COUNT_W-1:0] data,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               mode,
    output logic               alarm
);
    localparam logic [COUNT_W-1:0] ALL1 = '1;

    // A stopped timer that sits at its terminal value cannot be restarted.
    logic stuck;
    assign stuck = !running && (mode ? (count == ALL1) : (count == '0));

    // Command handling, with the tick-driven count update as the fallback.
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            count   <= '0;
            running <= 1'b0;
            mode    <= 1'b0;
            alarm   <= 1'b0;
        end else if (hit) begin
            case (op)
                OP_LOAD:  count <= data;
                OP_STSP:  if (!stuck) running <= !running;
                OP_CLEAR: begin
                    count   <= '0;
                    running <= 1'b0;
                    alarm   <= 1'b0;
                end
                OP_ACK:   alarm <= 1'b0;
                OP_MODE:  begin
                    mode    <= data[0];
                    running <= 1'b0;
                end
                default:  ;
            endcase
        end else if (tick && running) begin
            if (mode) begin
                // A stopwatch saturates at all-ones. It never wraps.
                if (count == ALL1) begin
                    running <= 1'b0;
                    alarm   <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                // A countdown that was loaded with 0 while running stops the
                // same way as a 1->0 transition. It does not wrap to all-ones.
                if (count == '0 || count == COUNT_W'(1)) begin
                    count   <= '0;
                    running <= 1'b0;
                    alarm   <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int COUNT_W   = 32,
    parameter int TICK_DIV  = 1000,
    parameter int LAP_DEPTH = 8,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clockSignal,
    input  logic                          resetN,
    input  logic                          cmdValid,
    input  logic [CW-1:0]                 cmdChannel,
    input  logic [2:0]                    cmdOp,
    input  logic [COUNT_W-1:0]            cmdData,
    output logic [CHANNELS*COUNT_W-1:0]   countOut,
    output logic [CHANNELS-1:0]           running,
    output logic [CHANNELS-1:0]           modeOut,
    output logic [CHANNELS-1:0]           alarm,
    output logic                          lapValid,
    input  logic                          lapReady,
    output logic [CW-1:0]                 lapChannel,
    output logic [COUNT_W-1:0]            lapData,
    output logic                          lapOverflow
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]                    presc;
    logic                             tick;
    logic [CHANNELS-1:0][COUNT_W-1:0] cnt;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    assign countOut = cnt;

    // Free-running prescaler. Commands never stop it.
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN)   presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        timer_chan #(.COUNT_W(COUNT_W)) u_chan (
            .clockSignal (clockSignal),
            .resetN      (resetN),
            .tick        (tick),
            .hit         (cmdValid && (cmdChannel == CW'(i))),
            .op          (cmdOp),
            .data        (cmdData),
            .count       (cnt[i]),
            .running     (running[i]),
            .mode        (modeOut[i]),
            .alarm       (alarm[i])
        );
    end

`ifdef TIMER_LAP_FIFO_EN
    localparam int AW = $clog2(LAP_DEPTH);

    logic [LAP_DEPTH-1:0][CW+COUNT_W-1:0] mem;
    logic [AW:0]                          wrPtr, rdPtr;
    logic                                 inRange, full, push, pop, ovf;

    if (CHANNELS == (1 << CW)) begin : g_rng_full
        assign inRange = 1'b1;
    end else begin : g_rng_cmp
        assign inRange = (cmdChannel < CW'(CHANNELS));
    end

    assign full        = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign lapValid    = (wrPtr != rdPtr);
    assign pop         = lapValid && lapReady;
    assign push        = cmdValid && (cmdOp == OP_SPLIT) && inRange;
    assign lapOverflow = ovf;
    // Output the head only while it is valid, so an empty FIFO reads as zero.
    assign {lapChannel, lapData} = lapValid ? mem[rdPtr[AW-1:0]] : '0;

    // Lap FIFO. A push into a full FIFO is kept when the head pops in the same cycle.
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            mem   <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            ovf   <= 1'b0;
        end else begin
            if (pop) rdPtr <= rdPtr + 1'b1;
            if (push) begin
                if (!full || pop) begin
                    mem[wrPtr[AW-1:0]] <= {cmdChannel, cnt[cmdChannel]};
                    wrPtr              <= wrPtr + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
            // CLR_OVF does not look at cmdChannel.
            if (cmdValid && (cmdOp == OP_CLR_OVF)) ovf <= 1'b0;
        end
    end
`else
    logic unused;
    assign unused      = &{1'b0, lapReady};
    assign lapValid    = 1'b0;
    assign lapChannel  = '0;
    assign lapData     = '0;
    assign lapOverflow = 1'b0;
`endif
endmodule

// File: tb/tb_timer_bank.sv
// Randomized plus directed bench for timer_bank, checked against a
// behavioural model built from the channel rules and a lap queue.
module tb_timer_bank;
    localparam int CH = 2, CWD = 8, TD = 4, LD = 2, CW = 1;
`ifdef TIMER_LAP_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic              clockSignal = 1'b0;
    logic              resetN;
    logic              cmdValid;
    logic [CW-1:0]     cmdChannel;
    logic [2:0]        cmdOp;
    logic [CWD-1:0]    cmdData;
    logic [CH*CWD-1:0] countOut;
    logic [CH-1:0]     running, modeOut, alarm;
    logic              lapValid, lapReady, lapOverflow;
    logic [CW-1:0]     lapChannel;
    logic [CWD-1:0]    lapData;

    timer_bank #(.CHANNELS(CH), .COUNT_W(CWD), .TICK_DIV(TD), .LAP_DEPTH(LD)) dut (
        .clockSignal (clockSignal),
        .resetN      (resetN),
        .cmdValid    (cmdValid),
        .cmdChannel  (cmdChannel),
        .cmdOp       (cmdOp),
        .cmdData     (cmdData),
        .countOut    (countOut),
        .running     (running),
        .modeOut     (modeOut),
        .alarm       (alarm),
        .lapValid    (lapValid),
        .lapReady    (lapReady),
        .lapChannel  (lapChannel),
        .lapData     (lapData),
        .lapOverflow (lapOverflow)
    );

    always #5 clockSignal = ~clockSignal;

    // Reference model state.
    int mCnt[CH];
    bit mRun[CH], mMode[CH], mAlm[CH];
    int mPre;
    int lapQ[$];
    bit mOvf;
    int nCmp = 0, nErr = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic mReset();
        for (int c = 0; c < CH; c++) begin
            mCnt[c] = 0; mRun[c] = 0; mMode[c] = 0; mAlm[c] = 0;
        end
        mPre = 0;
        mOvf = 0;
        lapQ.delete();
    endtask

    task automatic mStep(input bit v, input int ch, input int op, input int data, input bit rdy);
        bit tick, full, pop;
        tick = (mPre == TD - 1);
        mPre = (mPre + 1) % TD;
        if (FIFO_EN) begin
            full = (lapQ.size() == LD);
            pop  = (lapQ.size() > 0) && rdy;
            if (pop) void'(lapQ.pop_front());
            if (v && op == 3) begin
                if (!full || pop) lapQ.push_back(ch * 256 + mCnt[ch]);
                else mOvf = 1;
            end
            if (v && op == 7) mOvf = 0;
        end
        for (int c = 0; c < CH; c++) begin
            if (v && ch == c) begin
                case (op)
                    1: mCnt[c] = data;
                    2: if (mRun[c] || (mMode[c] ? mCnt[c] != 255 : mCnt[c] != 0)) mRun[c] = !mRun[c];
                    4: begin mCnt[c] = 0; mRun[c] = 0; mAlm[c] = 0; end
                    5: mAlm[c] = 0;
                    6: begin mMode[c] = data[0]; mRun[c] = 0; end
                    default: ;
                endcase
            end else if (tick && mRun[c]) begin
                if (mMode[c]) begin
                    if (mCnt[c] == 255) begin mRun[c] = 0; mAlm[c] = 1; end
                    else mCnt[c]++;
                end else begin
                    if (mCnt[c] <= 1) begin mCnt[c] = 0; mRun[c] = 0; mAlm[c] = 1; end
                    else mCnt[c]--;
                end
            end
        end
    endtask

    task automatic checkAll();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("count%0d", c), 32'(countOut[c*CWD +: CWD]), mCnt[c]);
            chk($sformatf("running%0d", c), 32'(running[c]), 32'(mRun[c]));
            chk($sformatf("mode%0d", c), 32'(modeOut[c]), 32'(mMode[c]));
            chk($sformatf("alarm%0d", c), 32'(alarm[c]), 32'(mAlm[c]));
        end
        chk("lapValid", 32'(lapValid), 32'(lapQ.size() > 0));
        chk("lapChannel", 32'(lapChannel), (lapQ.size() > 0) ? lapQ[0] / 256 : 0);
        chk("lapData", 32'(lapData), (lapQ.size() > 0) ? lapQ[0] % 256 : 0);
        chk("lapOverflow", 32'(lapOverflow), 32'(mOvf));
    endtask

    // Drive one cycle from the negedge, step the model, then check at the next negedge.
    task automatic cyc(input bit v, input int ch, input int op, input int data, input bit rdy);
        cmdValid   = v;
        cmdChannel = ch[CW-1:0];
        cmdOp      = op[2:0];
        cmdData    = data[CWD-1:0];
        lapReady   = rdy;
        mStep(v, ch, op, data, rdy);
        @(posedge clockSignal);
        @(negedge clockSignal);
        checkAll();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, rdy);
    endtask

    // Apply reset asynchronously between clock edges and check that outputs clear at once.
    task automatic midReset();
        resetN = 1'b0;
        #1;
        chk("rst_count", 32'(countOut), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_mode", 32'(modeOut), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_lapValid", 32'(lapValid), 0);
        chk("rst_lapOverflow", 32'(lapOverflow), 0);
        #1;
        resetN = 1'b1;
        mReset();
    endtask

    initial begin
        resetN = 1'b0; cmdValid = 0; cmdChannel = '0; cmdOp = '0; cmdData = '0; lapReady = 0;
        mReset();
        repeat (2) @(negedge clockSignal);
        checkAll();
        resetN = 1'b1;

        // Countdown 3 -> 0, alarm, ack.
        cyc(1, 0, 1, 3, 0);
        cyc(1, 0, 2, 0, 0);
        idle(16, 0);
        cyc(1, 0, 5, 0, 0);
        idle(2, 0);

        // Stopwatch saturation on channel 1; a restart after that is ignored.
        cyc(1, 1, 6, 1, 0);
        cyc(1, 1, 1, 254, 0);
        cyc(1, 1, 2, 0, 0);
        idle(10, 0);
        cyc(1, 1, 2, 0, 0);
        idle(2, 0);

        // Splits overflowing the lap FIFO, then drain and clear the overflow flag.
        cyc(1, 1, 5, 0, 0);
        cyc(1, 1, 1, 10, 0);
        cyc(1, 1, 2, 0, 0);
        idle(3, 0);
        cyc(1, 1, 3, 0, 0);
        idle(4, 0);
        cyc(1, 1, 3, 0, 0);
        idle(4, 0);
        cyc(1, 1, 3, 0, 0);
        idle(1, 0);
        idle(3, 1);
        cyc(1, 0, 7, 0, 0);

        // Fill the FIFO, then split and pop in the same cycle.
        cyc(1, 1, 3, 0, 0);
        idle(2, 0);
        cyc(1, 1, 3, 0, 0);
        idle(2, 0);
        cyc(1, 1, 3, 0, 1);
        idle(1, 0);
        idle(3, 1);

        // A command on a tick cycle wins over the tick.
        cyc(1, 0, 1, 20, 0);
        cyc(1, 0, 2, 0, 0);
        for (int k = 0; k < TD && mPre != TD - 1; k++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 10, 0);
        idle(3, 0);
        midReset();
        idle(3, 0);

        // Randomized traffic, with an occasional asynchronous reset.
        for (int n = 0; n < 800; n++) begin
            int op, data;
            op   = $urandom_range(0, 7);
            data = ($urandom_range(0, 3) == 0) ? 250 + $urandom_range(0, 5) : $urandom_range(0, 12);
            if ($urandom_range(0, 249) == 0) begin
                midReset();
            end
            cyc($urandom_range(0, 2) != 0, $urandom_range(0, CH - 1), op, data, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
